// File: rtl/inst_rom_resp_if.sv
// Fetch and program-loader signal bundle for inst_rom_resp.
// The slave modport is the ROM side; the master modport is the fetch stage / loader host.
interface inst_rom_resp_if #(
    parameter int ADDR_W = 10
);
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_inst;
    logic              inst_valid;
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_end;
    logic              load_ready;
    logic              load_busy;
    logic [ADDR_W:0]   load_words;
    logic              load_overflow;
    logic              fetch_err;

    modport slave (
        input  rom_ce, rom_addr, load_start, load_valid, load_byte, load_end,
        output rom_inst, inst_valid, load_ready, load_busy, load_words,
               load_overflow, fetch_err
    );

    modport master (
        output rom_ce, rom_addr, load_start, load_valid, load_byte, load_end,
        input  rom_inst, inst_valid, load_ready, load_busy, load_words,
               load_overflow, fetch_err
    );
endinterface

// File: rtl/inst_rom_resp.sv
// Instruction ROM responder with a little-endian byte-stream program loader.
// Optional ROM_ADDR_CHECK_EN flags misaligned or out-of-range fetches through a sticky fetch_err.
module inst_rom_resp #(
    parameter int DEPTH        = 1024,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 0
) (
    input logic          clk,
    input logic          rst,
    inst_rom_resp_if.slave bus
);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, COMMIT, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [2:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     word_q, word_d;
    logic [ADDR_W:0] wptr_q, wptr_d;
    logic [ADDR_W:0] words_q, words_d;
    logic            ovf_q, ovf_d;
    logic            end_pend_q, end_pend_d;
    logic            fetch_err_q, fetch_err_d;
    logic            mem_we;
    logic [31:0]     mem [DEPTH];

    logic [ADDR_W-1:0] fetch_idx;
    logic              addr_bad;
    logic [31:0]       fetch_data;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        wptr_d     = wptr_q;
        words_d    = words_q;
        ovf_d      = ovf_q;
        end_pend_d = end_pend_q;
        mem_we     = 1'b0;
        // load_start from any state restarts; a partial word is simply dropped.
        if (bus.load_start) begin
            state_d    = LOAD;
            byte_cnt_d = 3'd0;
            word_d     = 32'h0;
            wptr_d     = '0;
            words_d    = '0;
            ovf_d      = 1'b0;
            end_pend_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.load_valid) begin
                        word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = bus.load_byte;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                    if (bus.load_end || end_pend_q) begin
                        end_pend_d = 1'b0;
                        state_d    = (byte_cnt_d != 3'd0) ? FLUSH : IDLE;
                    end else if (byte_cnt_d == 3'd4) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT, FLUSH: begin
                    if (wptr_q < DEPTH_W) begin
                        mem_we  = 1'b1;
                        wptr_d  = wptr_q + 1'b1;
                        words_d = words_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    byte_cnt_d = 3'd0;
                    word_d     = 32'h0;
                    if (state_q == COMMIT) begin
                        state_d    = LOAD;
                        end_pend_d = end_pend_q | bus.load_end;
                    end else begin
                        state_d    = IDLE;
                        end_pend_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 3'd0;
            word_q      <= 32'h0;
            wptr_q      <= '0;
            words_q     <= '0;
            ovf_q       <= 1'b0;
            end_pend_q  <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            wptr_q      <= wptr_d;
            words_q     <= words_d;
            ovf_q       <= ovf_d;
            end_pend_q  <= end_pend_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Unpadded lanes are already zero because word_q is cleared on every commit/restart.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q[ADDR_W-1:0]] <= word_q;
        end
    end

    assign fetch_idx = bus.rom_addr[ADDR_W+1:2];

`ifdef ROM_ADDR_CHECK_EN
    assign addr_bad = (bus.rom_addr[1:0] != 2'b00) || (bus.rom_addr[31:ADDR_W+2] != '0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.rom_addr[31:ADDR_W+2], bus.rom_addr[1:0]};
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        fetch_data  = 32'h0;
        fetch_err_d = fetch_err_q | (bus.rom_ce & addr_bad);
        if (bus.rom_ce) begin
            fetch_data = (bus.load_busy || addr_bad) ? NOP : mem[fetch_idx];
        end
    end

    assign bus.load_ready    = (state_q == LOAD);
    assign bus.load_busy     = (state_q != IDLE);
    assign bus.load_words    = words_q;
    assign bus.load_overflow = ovf_q;
    assign bus.fetch_err     = fetch_err_q;

    generate
        if (READ_LATENCY == 0) begin : g_comb
            // Outputs are forced low while reset is held so the combinational path matches reset state.
            assign bus.rom_inst   = rst ? fetch_data : 32'h0;
            assign bus.inst_valid = rst & bus.rom_ce;
        end else begin : g_pipe
            for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
                logic [31:0] data_q, data_d;
                logic        vld_q, vld_d;
                if (gi == 0) begin : g_first
                    always_comb begin
                        data_d = fetch_data;
                        vld_d  = bus.rom_ce;
                    end
                end else begin : g_next
                    always_comb begin
                        data_d = g_stage[gi-1].data_q;
                        vld_d  = g_stage[gi-1].vld_q;
                    end
                end
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        data_q <= 32'h0;
                        vld_q  <= 1'b0;
                    end else begin
                        data_q <= data_d;
                        vld_q  <= vld_d;
                    end
                end
            end
            assign bus.rom_inst   = g_stage[READ_LATENCY-1].data_q;
            assign bus.inst_valid = g_stage[READ_LATENCY-1].vld_q;
        end
    endgenerate
endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
- Responder end of the core's instruction-fetch interface: accepts rom_ce/rom_addr from the fetch stage and returns rom_inst from a word-wide instruction memory.
- Includes a byte-stream program loader (FSM) that packs little-endian bytes into words and writes them into the memory before or between runs.
- Sits beside the CPU top in the testbench/SoC wrapper and replaces the ad-hoc ROM model.

Parameters:
- DEPTH, 1024, number of 32-bit instruction words; power of two.
- ADDR_W, 10, word-index width; log2(DEPTH).
- READ_LATENCY, 0, fetch latency in cycles; legal values 0, 1, 2. The value 0 is required for the current core.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- rom_ce  in  1  fetch enable from pc register
- rom_addr  in  32  byte address of fetch
- rom_inst  out  32  fetched instruction
- inst_valid  out  1  rom_inst carries the response to a fetch issued READ_LATENCY cycles earlier
- load_start  in  1  one-cycle pulse: begin a program load at word 0
- load_valid  in  1  load_byte is valid
- load_byte  in  8  program byte, little-endian within each word
- load_end  in  1  one-cycle pulse: flush any partial word and finish the load
- load_ready  out  1  loader accepts a byte this cycle
- load_busy  out  1  loader is not IDLE
- load_words  out  ADDR_W+1  count of words committed since the last load_start
- load_overflow  out  1  sticky: a commit was attempted past DEPTH
- fetch_err  out  1  sticky fetch-address error; see Optional Feature

Behaviour:
- Reset values (rst low, asynchronous): state IDLE, byte_cnt 0, wptr 0, load_words 0, load_overflow 0, fetch_err 0, rom_inst 0, inst_valid 0, latency pipeline cleared. Memory contents are not reset.
- Fetch word index is rom_addr[ADDR_W+1:2].
- Fetch data is selected as follows:
  - rom_ce=0: 0x00000000.
  - load_busy=1: NOP 0x00000013.
  - Otherwise: mem[index].
- READ_LATENCY=0: rom_inst and inst_valid (=rom_ce) are combinational.
- READ_LATENCY=1 or 2: data and ce are registered through a READ_LATENCY-deep pipeline. A fetch issued every cycle returns one word every cycle. There is no back-pressure.
- Loader FSM states: IDLE, LOAD, COMMIT, FLUSH.
- IDLE: on load_start, go to LOAD and clear wptr, byte_cnt, load_words and load_overflow.
- LOAD:
  - load_ready=1.
  - A byte is accepted on load_valid&&load_ready into lane byte_cnt (lane 0 = bits 7:0), and byte_cnt increments.
  - After the 4th byte, go to COMMIT.
  - On load_end:
    - byte_cnt!=0: go to FLUSH.
    - byte_cnt==0: go to IDLE.
  - If load_end and load_valid occur in the same cycle, the byte is accepted first, then load_end is evaluated.
- COMMIT: one cycle, load_ready=0.
  - wptr<DEPTH: write mem[wptr], then increment wptr and load_words.
  - Otherwise: drop the word and set load_overflow.
  - Then clear byte_cnt and return to LOAD.
  - A load_end that arrives during COMMIT is held and acted on in LOAD on the next cycle.
- FLUSH: zero-pad the unfilled lanes and commit as in COMMIT, then go to IDLE.
- load_start in any non-IDLE state restarts the load: the partial word is discarded and the pointers and counters are cleared.
- A commit and a fetch to the same word in the same cycle read the old data; the write takes effect at the clock edge.
- Reset asserted mid-load aborts to IDLE. Words already committed remain in memory.

Optional Feature:
- Macro: ROM_ADDR_CHECK_EN.
- Defined: a fetch with rom_ce=1 and either rom_addr[1:0]!=0 or rom_addr[31:ADDR_W+2]!=0 sets fetch_err, which is sticky until reset. That fetch returns NOP 0x00000013.
- Undefined: the address is truncated to its word index (modulo DEPTH) and fetch_err is tied to 0.

Test Plan:
- Reset: hold rst low mid-stream -> all outputs 0, load_busy=0. Release, then rom_ce=1 -> inst_valid=1 at latency 0.
- Load bytes 13,05,10,00,93,00,10,00 then pulse load_end -> load_words=2. Fetch addr 0x0 -> 0x00100513; fetch addr 0x4 -> 0x00100093.
- Load 5 bytes 01,02,03,04,AA then load_end -> load_words=2. Fetch addr 0x4 -> 0x000000AA (FLUSH zero-pad).
- Fetch while load_busy=1 -> rom_inst=0x00000013. Run with READ_LATENCY=2 and back-to-back fetches of 0x0 and 0x4 -> data appears 2 cycles later, one word per cycle.
- DEPTH=4: load 20 bytes -> load_words=4, load_overflow=1, mem[0..3] intact. load_start -> load_overflow clears.
- With ROM_ADDR_CHECK_EN: fetch 0x2 -> NOP, fetch_err=1 and stays 1. Without it: fetch 0x1000 with DEPTH=1024 -> returns mem[0], fetch_err=0.
